// File: rtl/ms72xx_cfg_sequencer.sv
// Register-init sequencer for the MS7200/MS7210 HDMI bridge pair: walks a ROM
// table and issues one IIC byte write per entry, with delays, NACK retries and restart.
module ms72xx_cfg_sequencer #(
    parameter int          ROM_AW       = 8,
    parameter int          CLK_FREQ_KHZ = 10000,
    parameter int          PWR_WAIT_MS  = 2,
    parameter int          MAX_RETRY    = 3,
    parameter int          RETRY_GAP    = 1000,
    parameter logic [7:0]  DEV_ADDR_RX  = 8'hB2,
    parameter logic [7:0]  DEV_ADDR_TX  = 8'hB2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [7:0]        cmd_dev_addr,
    output logic [15:0]       cmd_reg_addr,
    output logic [7:0]        cmd_wdata,
    input  logic              cmd_done,
    input  logic              cmd_nack,
    output logic              bus_sel,
    output logic              init_over,
    output logic              cfg_err,
    output logic              busy
);

    localparam int MS_W  = (CLK_FREQ_KHZ > 1) ? $clog2(CLK_FREQ_KHZ) : 1;
    localparam int ACC_W = (PWR_WAIT_MS > 255) ? $clog2(PWR_WAIT_MS + 1) : 8;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GAP_W = (RETRY_GAP > 1) ? $clog2(RETRY_GAP + 1) : 1;

    typedef enum logic [3:0] {
        ST_PWR_WAIT, ST_FETCH, ST_LATCH, ST_DECODE, ST_ISSUE, ST_WAIT_DONE,
        ST_GAP, ST_DELAY, ST_NEXT, ST_DONE, ST_ERR
    } state_t;

    state_t              state_reg, state_next;
    logic [ROM_AW-1:0]   rom_addr_reg;
    logic [MS_W-1:0]     ms_cnt_reg;
    logic [ACC_W-1:0]    ms_acc_reg;
    logic [RTY_W-1:0]    retry_cnt_reg;
    logic [GAP_W-1:0]    gap_cnt_reg;
    logic                ent_end_reg, ent_delay_reg, ent_dev_reg;
    logic [15:0]         ent_reg_addr_reg;
    logic [7:0]          ent_data_reg;
    logic [7:0]          cmd_dev_addr_reg, cmd_wdata_reg;
    logic [15:0]         cmd_reg_addr_reg;
    logic                bus_sel_reg, init_over_reg, cfg_err_reg, busy_reg;
    logic                ms_tick, pwr_wait_done, delay_done, gap_done, reserved_unused;

    assign reserved_unused = ^rom_data[28:24];

    assign ms_tick       = (ms_cnt_reg == MS_W'(CLK_FREQ_KHZ - 1));
    assign pwr_wait_done = (PWR_WAIT_MS == 0) ||
                           (ms_tick && ms_acc_reg == ACC_W'(PWR_WAIT_MS - 1));
    assign delay_done    = ms_tick && (ms_acc_reg == ACC_W'(ent_data_reg - 8'd1));
    assign gap_done      = (gap_cnt_reg == GAP_W'(RETRY_GAP - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_PWR_WAIT:  if (pwr_wait_done) state_next = ST_FETCH;
            ST_FETCH:     state_next = ST_LATCH;
            ST_LATCH:     state_next = ST_DECODE;
            ST_DECODE: begin
                if (ent_end_reg)
                    state_next = ST_DONE;
                else if (ent_delay_reg)
                    state_next = (ent_data_reg == 8'd0) ? ST_NEXT : ST_DELAY;
                else
                    state_next = ST_ISSUE;
            end
            ST_ISSUE:     if (cmd_ready) state_next = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (cmd_done) begin
                    if (!cmd_nack)
                        state_next = ST_NEXT;
                    else if (retry_cnt_reg >= RTY_W'(MAX_RETRY))
                        state_next = ST_ERR;
                    else
                        state_next = ST_GAP;
                end
            end
            ST_GAP:       if (gap_done) state_next = ST_ISSUE;
            ST_DELAY:     if (delay_done) state_next = ST_NEXT;
            ST_NEXT:      state_next = (&rom_addr_reg) ? ST_DONE : ST_FETCH;
            ST_DONE,
            ST_ERR:       if (restart) state_next = ST_PWR_WAIT;
            default:      state_next = ST_PWR_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_PWR_WAIT;
            rom_addr_reg     <= '0;
            retry_cnt_reg    <= '0;
            ent_end_reg      <= 1'b0;
            ent_delay_reg    <= 1'b0;
            ent_dev_reg      <= 1'b0;
            ent_reg_addr_reg <= '0;
            ent_data_reg     <= '0;
            cmd_dev_addr_reg <= '0;
            cmd_reg_addr_reg <= '0;
            cmd_wdata_reg    <= '0;
            bus_sel_reg      <= 1'b0;
            init_over_reg    <= 1'b0;
            cfg_err_reg      <= 1'b0;
            busy_reg         <= 1'b1;
        end else begin
            state_reg     <= state_next;
            init_over_reg <= (state_next == ST_DONE);
            cfg_err_reg   <= (state_next == ST_ERR);
            busy_reg      <= !(state_next == ST_DONE || state_next == ST_ERR);

            if (state_reg == ST_LATCH) begin
                ent_end_reg      <= rom_data[31];
                ent_delay_reg    <= rom_data[30];
                ent_dev_reg      <= rom_data[29];
                ent_reg_addr_reg <= rom_data[23:8];
                ent_data_reg     <= rom_data[7:0];
            end

            // cmd_* and bus_sel stay frozen through GAP so a retry re-issues the identical write
            if (state_reg == ST_DECODE && !ent_end_reg && !ent_delay_reg) begin
                cmd_dev_addr_reg <= ent_dev_reg ? DEV_ADDR_TX : DEV_ADDR_RX;
                cmd_reg_addr_reg <= ent_reg_addr_reg;
                cmd_wdata_reg    <= ent_data_reg;
                bus_sel_reg      <= ent_dev_reg;
                retry_cnt_reg    <= '0;
            end else if (state_reg == ST_WAIT_DONE && state_next == ST_GAP) begin
                retry_cnt_reg <= retry_cnt_reg + RTY_W'(1);
            end

            if (state_reg == ST_NEXT && !(&rom_addr_reg))
                rom_addr_reg <= rom_addr_reg + ROM_AW'(1);
            else if ((state_reg == ST_DONE || state_reg == ST_ERR) && restart)
                rom_addr_reg <= '0;
        end
    end

    // Millisecond timebase, shared by the power-up wait and DELAY entries
    always_ff @(posedge clk) begin
        if (rst) begin
            ms_cnt_reg <= '0;
            ms_acc_reg <= '0;
        end else if (state_reg == ST_PWR_WAIT || state_reg == ST_DELAY) begin
            if (ms_tick) begin
                ms_cnt_reg <= '0;
                ms_acc_reg <= ms_acc_reg + ACC_W'(1);
            end else begin
                ms_cnt_reg <= ms_cnt_reg + MS_W'(1);
            end
        end else begin
            ms_cnt_reg <= '0;
            ms_acc_reg <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state_reg != ST_GAP)
            gap_cnt_reg <= '0;
        else
            gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
    end

    assign rom_addr     = rom_addr_reg;
    assign cmd_valid    = (state_reg == ST_ISSUE);
    assign cmd_dev_addr = cmd_dev_addr_reg;
    assign cmd_reg_addr = cmd_reg_addr_reg;
    assign cmd_wdata    = cmd_wdata_reg;
    assign bus_sel      = bus_sel_reg;
    assign init_over    = init_over_reg;
    assign cfg_err      = cfg_err_reg;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_ms72xx_cfg_sequencer.sv
// Directed bench for ms72xx_cfg_sequencer: ROM model, IIC master model with
// programmable stall/NACK, table-driven write checks plus timing/corner sequences.
module tb_ms72xx_cfg_sequencer;

    localparam int         ROM_AW    = 3;
    localparam int         CLK_KHZ   = 10;
    localparam int         PWR_MS    = 2;
    localparam int         MAX_RTY   = 3;
    localparam int         GAP       = 200;
    localparam logic [7:0] DEV_RX    = 8'hB2;
    localparam logic [7:0] DEV_TX    = 8'hB4;
    localparam int         DONE_DLY  = 20;
    localparam int         PWR_CYC   = PWR_MS * CLK_KHZ;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              restart = 1'b0;
    logic [ROM_AW-1:0] rom_addr;
    logic [31:0]       rom_data = '0;
    logic              cmd_valid;
    logic              cmd_ready = 1'b0;
    logic [7:0]        cmd_dev_addr;
    logic [15:0]       cmd_reg_addr;
    logic [7:0]        cmd_wdata;
    logic              cmd_done = 1'b0;
    logic              cmd_nack = 1'b0;
    logic              bus_sel, init_over, cfg_err, busy;

    ms72xx_cfg_sequencer #(
        .ROM_AW(ROM_AW), .CLK_FREQ_KHZ(CLK_KHZ), .PWR_WAIT_MS(PWR_MS),
        .MAX_RETRY(MAX_RTY), .RETRY_GAP(GAP), .DEV_ADDR_RX(DEV_RX), .DEV_ADDR_TX(DEV_TX)
    ) dut (
        .clk(clk), .rst(rst), .restart(restart),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dev_addr(cmd_dev_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
        .cmd_done(cmd_done), .cmd_nack(cmd_nack), .bus_sel(bus_sel),
        .init_over(init_over), .cfg_err(cfg_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] entry;
        logic        is_wr;
        logic [7:0]  exp_dev;
        logic [15:0] exp_reg;
        logic [7:0]  exp_data;
        logic        exp_bus;
    } vec_t;

    vec_t vec [8];

    function automatic vec_t mk_wr(input logic tx, input logic [15:0] ra, input logic [7:0] d);
        vec_t v;
        v.entry    = {1'b0, 1'b0, tx, 5'b0, ra, d};
        v.is_wr    = 1'b1;
        v.exp_dev  = tx ? DEV_TX : DEV_RX;
        v.exp_reg  = ra;
        v.exp_data = d;
        v.exp_bus  = tx;
        return v;
    endfunction

    function automatic vec_t mk_dly(input logic [7:0] ms);
        vec_t v;
        v = '0;
        v.entry = {2'b01, 6'b0, 16'h0000, ms};
        return v;
    endfunction

    function automatic vec_t mk_end();
        vec_t v;
        v = '0;
        v.entry = 32'h8000_0000;
        return v;
    endfunction

    // Synchronous ROM, one cycle of read latency
    logic [31:0] rom_mem [8];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Master model state and capture
    int          stall_left = 0;
    int          nacks_left = 0;
    int          m_state = 0;
    int          m_cnt = 0;
    logic        prev_valid = 1'b0;
    logic        ref_set = 1'b0;
    logic        stable_err = 1'b0;
    logic [32:0] ref_cmd;
    int          hs_n = 0, vn = 0, dn = 0;
    logic [7:0]  hs_dev [16];
    logic [15:0] hs_reg [16];
    logic [7:0]  hs_data [16];
    logic        hs_bus [16];
    int          hs_cyc [16];
    int          vrise [16];
    int          done_cyc [16];

    int checks = 0;
    int errors = 0;

    always @(negedge clk) begin
        cmd_done = 1'b0;
        cmd_nack = 1'b0;
        if (rst) begin
            m_state    = 0;
            m_cnt      = 0;
            cmd_ready  = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (cmd_valid && !prev_valid && vn < 16) begin
                vrise[vn] = cyc;
                vn++;
            end
            prev_valid = cmd_valid;
            case (m_state)
                0: if (cmd_valid) begin
                    if (ref_set && {cmd_dev_addr, cmd_reg_addr, cmd_wdata, bus_sel} != ref_cmd)
                        stable_err = 1'b1;
                    if (stall_left > 0) begin
                        if (!ref_set) begin
                            ref_cmd = {cmd_dev_addr, cmd_reg_addr, cmd_wdata, bus_sel};
                            ref_set = 1'b1;
                        end
                        stall_left--;
                    end else begin
                        cmd_ready = 1'b1;
                        ref_set   = 1'b0;
                        if (hs_n < 16) begin
                            hs_dev[hs_n]  = cmd_dev_addr;
                            hs_reg[hs_n]  = cmd_reg_addr;
                            hs_data[hs_n] = cmd_wdata;
                            hs_bus[hs_n]  = bus_sel;
                            hs_cyc[hs_n]  = cyc;
                        end
                        $display("hs %0d @%0d: dev=%h reg=%h data=%h bus=%b",
                                 hs_n, cyc, cmd_dev_addr, cmd_reg_addr, cmd_wdata, bus_sel);
                        hs_n++;
                        m_state = 1;
                    end
                end
                1: begin
                    cmd_ready = 1'b0;
                    m_cnt     = 0;
                    m_state   = 2;
                end
                default: begin
                    m_cnt++;
                    if (m_cnt == DONE_DLY) begin
                        cmd_done = 1'b1;
                        cmd_nack = (nacks_left > 0);
                        if (nacks_left > 0) nacks_left--;
                        if (dn < 16) done_cyc[dn] = cyc;
                        dn++;
                        m_state = 0;
                    end
                end
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_cap();
        hs_n = 0;
        vn   = 0;
        dn   = 0;
    endtask

    task automatic load_rom();
        for (int i = 0; i < 8; i++) rom_mem[i] = vec[i].entry;
    endtask

    task automatic pulse_restart(output int at);
        @(negedge clk);
        restart = 1'b1;
        at = cyc;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int i;
        for (i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        checks++;
        if (i == max_cyc) begin
            errors++;
            $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", name, max_cyc);
        end
    endtask

    task automatic wait_hs(input string name, input int n, input int max_cyc);
        int i;
        for (i = 0; i < max_cyc; i++) begin
            if (hs_n >= n) break;
            @(negedge clk);
        end
        checks++;
        if (i == max_cyc) begin
            errors++;
            $display("FAIL %s_timeout: %0d handshakes, required %0d", name, hs_n, n);
        end
    endtask

    task automatic check_table(input string name);
        int k;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            if (vec[i].is_wr && k < 16) begin
                chk($sformatf("%s_dev%0d", name, k), 32'(hs_dev[k]), 32'(vec[i].exp_dev));
                chk($sformatf("%s_reg%0d", name, k), 32'(hs_reg[k]), 32'(vec[i].exp_reg));
                chk($sformatf("%s_dat%0d", name, k), 32'(hs_data[k]), 32'(vec[i].exp_data));
                chk($sformatf("%s_bus%0d", name, k), 32'(hs_bus[k]), 32'(vec[i].exp_bus));
                k++;
            end
        end
    endtask

    initial begin
        int t0;
        int r;

        // Basic table: three writes then END
        vec[0] = mk_wr(1'b0, 16'h0003, 8'h5A);
        vec[1] = mk_wr(1'b1, 16'h1000, 8'h01);
        vec[2] = mk_wr(1'b0, 16'h0004, 8'hFF);
        for (int i = 3; i < 8; i++) vec[i] = mk_end();
        load_rom();

        repeat (3) @(negedge clk);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_init_over", 32'(init_over), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_bus_sel", 32'(bus_sel), 32'd0);

        clear_cap();
        rst = 1'b0;
        t0 = cyc;
        wait_idle("t1", 2000);
        chk("t1_hs_count", 32'(hs_n), 32'd3);
        check_table("t1");
        chk("t1_first_valid_lat", 32'(vrise[0] - t0), 32'(PWR_CYC + 3));
        chk("t1_init_over", 32'(init_over), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_cfg_err", 32'(cfg_err), 32'd0);

        // DELAY 5 ms and DELAY 0 between writes
        vec[0] = mk_wr(1'b0, 16'h0010, 8'h11);
        vec[1] = mk_dly(8'd5);
        vec[2] = mk_wr(1'b1, 16'h0011, 8'h22);
        vec[3] = mk_dly(8'd0);
        vec[4] = mk_wr(1'b0, 16'h0012, 8'h33);
        for (int i = 5; i < 8; i++) vec[i] = mk_end();
        load_rom();
        clear_cap();
        pulse_restart(r);
        wait_idle("t2", 2000);
        chk("t2_hs_count", 32'(hs_n), 32'd3);
        check_table("t2");
        // done -> NEXT,FETCH,LATCH,DECODE, 5*CLK_KHZ in DELAY, NEXT,FETCH,LATCH,DECODE,ISSUE
        chk("t2_delay5_gap", 32'(vrise[1] - done_cyc[0]), 32'(5 * CLK_KHZ + 9));
        chk("t2_delay0_gap", 32'(vrise[2] - done_cyc[1]), 32'd9);

        // Two NACKs then ACK on one entry
        vec[0] = mk_wr(1'b1, 16'h2000, 8'hAA);
        for (int i = 1; i < 8; i++) vec[i] = mk_end();
        load_rom();
        clear_cap();
        nacks_left = 2;
        pulse_restart(r);
        wait_idle("t3", 3000);
        chk("t3_hs_count", 32'(hs_n), 32'd3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t3_reg%0d", k), 32'(hs_reg[k]), 32'h2000);
            chk($sformatf("t3_dat%0d", k), 32'(hs_data[k]), 32'hAA);
            chk($sformatf("t3_dev%0d", k), 32'(hs_dev[k]), 32'(DEV_TX));
        end
        chk("t3_retry_gap1", 32'(vrise[1] - done_cyc[0]), 32'(GAP + 1));
        chk("t3_retry_gap2", 32'(vrise[2] - done_cyc[1]), 32'(GAP + 1));
        chk("t3_init_over", 32'(init_over), 32'd1);
        chk("t3_cfg_err", 32'(cfg_err), 32'd0);

        // Permanent NACK exhausts the retry budget, then restart recovers
        vec[0] = mk_wr(1'b0, 16'h0020, 8'h44);
        vec[1] = mk_wr(1'b1, 16'h0021, 8'h77);
        for (int i = 2; i < 8; i++) vec[i] = mk_end();
        load_rom();
        clear_cap();
        nacks_left = 100;
        pulse_restart(r);
        wait_idle("t4", 5000);
        chk("t4_hs_count", 32'(hs_n), 32'(MAX_RTY + 1));
        chk("t4_last_reg", 32'(hs_reg[MAX_RTY]), 32'h0020);
        chk("t4_cfg_err", 32'(cfg_err), 32'd1);
        chk("t4_init_over", 32'(init_over), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        nacks_left = 0;
        clear_cap();
        pulse_restart(r);
        chk("t4_restart_clears_err", 32'(cfg_err), 32'd0);
        wait_idle("t4b", 2000);
        chk("t4b_hs_count", 32'(hs_n), 32'd2);
        check_table("t4b");
        chk("t4b_restart_lat", 32'(vrise[0] - r), 32'(PWR_CYC + 4));
        chk("t4b_cfg_err", 32'(cfg_err), 32'd0);
        chk("t4b_init_over", 32'(init_over), 32'd1);

        // Stalled ready, ignored restart in WAIT_DONE, rst in WAIT_DONE
        vec[0] = mk_wr(1'b0, 16'h0030, 8'h55);
        vec[1] = mk_wr(1'b1, 16'h0031, 8'h66);
        for (int i = 2; i < 8; i++) vec[i] = mk_end();
        load_rom();
        clear_cap();
        stall_left = 50;
        stable_err = 1'b0;
        ref_set    = 1'b0;
        pulse_restart(r);
        wait_hs("t5_first", 1, 500);
        chk("t5_stall_len", 32'(hs_cyc[0] - vrise[0]), 32'd50);
        chk("t5_stable", 32'(stable_err), 32'd0);
        chk("t5_stall_reg", 32'(hs_reg[0]), 32'h0030);
        repeat (3) @(negedge clk);
        pulse_restart(r);
        chk("t5_restart_ignored_busy", 32'(busy), 32'd1);
        wait_hs("t5_second", 2, 500);
        chk("t5_restart_ignored_gap", 32'(vrise[1] - done_cyc[0]), 32'd5);
        chk("t5_second_reg", 32'(hs_reg[1]), 32'h0031);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("t5_rst_dev", 32'(cmd_dev_addr), 32'd0);
        chk("t5_rst_reg", 32'(cmd_reg_addr), 32'd0);
        chk("t5_rst_wdata", 32'(cmd_wdata), 32'd0);
        chk("t5_rst_bus_sel", 32'(bus_sel), 32'd0);
        chk("t5_rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd1);
        chk("t5_rst_init_over", 32'(init_over), 32'd0);
        chk("t5_rst_cfg_err", 32'(cfg_err), 32'd0);
        clear_cap();
        rst = 1'b0;
        wait_idle("t5c", 2000);
        chk("t5c_hs_count", 32'(hs_n), 32'd2);
        chk("t5c_init_over", 32'(init_over), 32'd1);

        // Full ROM of writes: implicit END at the last address
        for (int i = 0; i < 8; i++)
            vec[i] = mk_wr(1'(i % 2), 16'h0100 + 16'(i), 8'h10 + 8'(i));
        load_rom();
        clear_cap();
        pulse_restart(r);
        wait_idle("t6", 4000);
        chk("t6_hs_count", 32'(hs_n), 32'd8);
        check_table("t6");
        chk("t6_rom_addr", 32'(rom_addr), 32'd7);
        chk("t6_init_over", 32'(init_over), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ms72xx_cfg_sequencer.md
Name: ms72xx_cfg_sequencer

Overview:
Configuration sequencer for the HDMI RX (MS7200) and TX (MS7210) bridge chips. It walks a register-init table held in an external synchronous ROM and issues one write per entry to a shared IIC byte-write master. A bus_sel output steers that master onto the RX or TX IIC bus. It handles per-entry delays, NACK retries and re-initialisation requests, and raises init_over to release the pixel datapath.

Parameters:
ROM_AW, 8, ROM address width; the table holds at most 2^ROM_AW entries
CLK_FREQ_KHZ, 10000, clk frequency in kHz; one ms tick = CLK_FREQ_KHZ cycles
PWR_WAIT_MS, 2, wait after reset/restart before the first fetch, in ms
MAX_RETRY, 3, re-issues allowed per entry after a NACK
RETRY_GAP, 1000, idle cycles between a NACK and the re-issue
DEV_ADDR_RX, 8'hB2, 8-bit IIC write address of the RX chip
DEV_ADDR_TX, 8'hB2, 8-bit IIC write address of the TX chip

Ports:
clk  in  1  configuration clock (10 MHz)
rst  in  1  synchronous, active-high reset
restart  in  1  single-cycle pulse; re-runs the table from entry 0
rom_addr  out  ROM_AW  table address
rom_data  in  32  table entry, valid 1 cycle after rom_addr: [31]=END, [30]=DELAY, [29]=dev_sel (0=RX, 1=TX), [28:24] reserved, [23:8]=reg_addr, [7:0]=data/delay_ms
cmd_valid  out  1  write request to the IIC master
cmd_ready  in  1  master accepts the request when cmd_valid && cmd_ready
cmd_dev_addr  out  8  device address
cmd_reg_addr  out  16  register address
cmd_wdata  out  8  write data
cmd_done  in  1  single-cycle pulse: transaction finished
cmd_nack  in  1  qualifies cmd_done; 1 = slave NACK
bus_sel  out  1  0 = RX IIC bus, 1 = TX IIC bus; stable from issue until done
init_over  out  1  table completed without error
cfg_err  out  1  retry budget exhausted
busy  out  1  sequencer is not in DONE or ERR

Behaviour:
- Reset: state = PWR_WAIT, rom_addr = 0, cmd_valid = 0, cmd_* = 0, bus_sel = 0, init_over = 0, cfg_err = 0, busy = 1. All counters = 0.
- States:
  - PWR_WAIT: wait PWR_WAIT_MS ms, then go to FETCH.
  - FETCH: present rom_addr, go to LATCH.
  - LATCH: register rom_data (1-cycle ROM latency), go to DECODE.
  - DECODE (priority END > DELAY > write):
    - END: go to DONE.
    - DELAY: data == 0 goes straight to NEXT; otherwise go to DELAY for data × CLK_FREQ_KHZ cycles, then NEXT.
    - Write: load cmd_* and bus_sel, clear retry_cnt, go to ISSUE.
  - ISSUE: cmd_valid = 1 and cmd_* held stable until the handshake. On cmd_valid && cmd_ready, drop cmd_valid the next cycle and go to WAIT_DONE.
  - WAIT_DONE, on cmd_done:
    - nack = 0: go to NEXT.
    - nack = 1 and retry_cnt < MAX_RETRY: retry_cnt++, go to GAP.
    - nack = 1 and retry_cnt == MAX_RETRY: go to ERR.
  - GAP: wait RETRY_GAP cycles, go to ISSUE with the same entry.
  - NEXT: if rom_addr is all ones, go to DONE (implicit END). Otherwise rom_addr++ and go to FETCH.
  - DONE: init_over = 1, busy = 0.
  - ERR: cfg_err = 1, init_over = 0, busy = 0.
- restart:
  - Honoured only in DONE or ERR. It clears init_over, cfg_err and rom_addr, and returns to PWR_WAIT.
  - Ignored in every other state, so an in-flight IIC transaction is never abandoned.
- rst mid-transaction: the sequencer returns to reset values immediately. The IIC master must be reset by the same rst.
- cmd_done arriving outside WAIT_DONE is ignored. cmd_done and cmd_ready in the same cycle as the issue handshake are not possible: the master asserts done at least 1 cycle after accept.
- Counters:
  - ms counter: 0..CLK_FREQ_KHZ-1, with a 1-cycle tick at wrap.
  - ms accumulator: 8 bits, or enough for PWR_WAIT_MS.
  - retry_cnt: clog2(MAX_RETRY+1) bits.
- Outputs: init_over, cfg_err and busy are registered, with no combinational path from inputs. The downstream pixel path gates on init_over.
- Latency: a write entry reaches cmd_valid 3 cycles after FETCH (FETCH → LATCH → DECODE → ISSUE).

Test Plan:
1. Table of 3 writes (RX 0x0003=0x5A, TX 0x1000=0x01, RX 0x0004=0xFF) plus END, master always ready with done 20 cycles later → exactly 3 handshakes carrying the exact addresses/data, bus_sel = 0,1,0; init_over = 1, busy = 0; first cmd_valid at PWR_WAIT_MS×CLK_FREQ_KHZ + 3 cycles after rst release.
2. DELAY entry with data = 5 between two writes (CLK_FREQ_KHZ = 10 for sim) → second cmd_valid ≥ 50 cycles after the first done; a DELAY with data = 0 adds only the NEXT/FETCH overhead.
3. NACK twice then ACK on one entry (MAX_RETRY = 3) → 3 issues of identical cmd_*, each ≥ RETRY_GAP cycles after the prior done; sequence completes with init_over = 1, cfg_err = 0.
4. Permanent NACK → MAX_RETRY+1 = 4 issues, then cfg_err = 1, init_over = 0, busy = 0; a subsequent restart re-runs from entry 0 and clears cfg_err.
5. cmd_ready held low 50 cycles → cmd_valid and cmd_* stable throughout; restart pulsed during WAIT_DONE is ignored; rst asserted in WAIT_DONE → all outputs at reset values the next cycle.
6. ROM filled with writes only, ROM_AW = 3 → 8 writes issued, then DONE via implicit END at address 7.
